// File: rtl/sram22_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram22_rr_arbiter
//  Purpose  : Two-port round-robin arbiter/sequencer for one sram22 macro,
//             fixed-latency read return to the originating requester.
//  Revision : 1.0
// ============================================================================
module sram22_rr_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic                   a_we,
   input  logic [WMASK_WIDTH-1:0] a_wmask,
   input  logic [ADDR_WIDTH-1:0]  a_addr,
   input  logic [DATA_WIDTH-1:0]  a_din,
   output logic                   a_rvalid,
   output logic [DATA_WIDTH-1:0]  a_rdata,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic                   b_we,
   input  logic [WMASK_WIDTH-1:0] b_wmask,
   input  logic [ADDR_WIDTH-1:0]  b_addr,
   input  logic [DATA_WIDTH-1:0]  b_din,
   output logic                   b_rvalid,
   output logic [DATA_WIDTH-1:0]  b_rdata,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   localparam logic c_SRC_A = 1'b0;
   localparam logic c_SRC_B = 1'b1;

   logic                   r_prio;
   logic                   r_sram_we;
   logic [WMASK_WIDTH-1:0] r_sram_wmask;
   logic [ADDR_WIDTH-1:0]  r_sram_addr;
   logic [DATA_WIDTH-1:0]  r_sram_din;
   logic                   r_issue_rd;
   logic                   r_issue_src;
   logic                   r_rsp_v;
   logic                   r_rsp_src;
   logic                   w_grant_a;
   logic                   w_grant_b;

   // A sole requester always wins; a contested cycle goes to the prio port.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (!rst) begin
         w_grant_a = a_valid && (!b_valid || (r_prio == c_SRC_A));
         w_grant_b = b_valid && (!a_valid || (r_prio == c_SRC_B));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio       <= c_SRC_A;
         r_sram_we    <= 1'b0;
         r_sram_wmask <= '0;
         r_sram_addr  <= '0;
         r_sram_din   <= '0;
         r_issue_rd   <= 1'b0;
         r_issue_src  <= c_SRC_A;
         r_rsp_v      <= 1'b0;
         r_rsp_src    <= c_SRC_A;
      end else begin
         if (w_grant_a) begin
            r_sram_we    <= a_we;
            r_sram_wmask <= a_wmask;
            r_sram_addr  <= a_addr;
            r_sram_din   <= a_din;
            r_issue_rd   <= !a_we;
            r_issue_src  <= c_SRC_A;
            r_prio       <= c_SRC_B;
         end else if (w_grant_b) begin
            r_sram_we    <= b_we;
            r_sram_wmask <= b_wmask;
            r_sram_addr  <= b_addr;
            r_sram_din   <= b_din;
            r_issue_rd   <= !b_we;
            r_issue_src  <= c_SRC_B;
            r_prio       <= c_SRC_A;
         end else begin
            // Idle: address/data hold, the macro's incidental read is discarded.
            r_sram_we    <= 1'b0;
            r_sram_wmask <= '0;
            r_issue_rd   <= 1'b0;
         end
         r_rsp_v   <= r_issue_rd;
         r_rsp_src <= r_issue_src;
      end
   end

   assign a_ready    = w_grant_a;
   assign b_ready    = w_grant_b;
   assign sram_we    = r_sram_we;
   assign sram_wmask = r_sram_wmask;
   assign sram_addr  = r_sram_addr;
   assign sram_din   = r_sram_din;
   assign a_rvalid   = r_rsp_v && (r_rsp_src == c_SRC_A);
   assign b_rvalid   = r_rsp_v && (r_rsp_src == c_SRC_B);
   assign a_rdata    = sram_dout;
   assign b_rdata    = sram_dout;

endmodule
`default_nettype wire
